mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one external memory port between instruction fetch (IF) and data memory (DM).
// Optional IF starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IF_Read,
  input  logic [31:0] IF_Address,
  output logic [31:0] IF_ReadData,
  output logic        IF_Ack,
  input  logic        DM_Read,
  input  logic        DM_Write,
  input  logic [31:0] DM_Address,
  input  logic [31:0] DM_WriteData,
  input  logic [3:0]  DM_ByteEnable,
  output logic [31:0] DM_ReadData,
  output logic        DM_Ack,
  output logic [31:0] Mem_Address,
  output logic [31:0] Mem_WriteData,
  output logic [3:0]  Mem_ByteEnable,
  output logic        Mem_ReadEnable,
  output logic        Mem_WriteEnable,
  input  logic [31:0] Mem_ReadData,
  input  logic        Mem_Ack,
  output logic        Err
);

  if (TIMEOUT < 1 || TIMEOUT > 65535 || STARVE_LIMIT < 1) begin : g_param_check
    $error("mem_port_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_e;

  state_e      state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;
  logic        err_q, err_d;
  logic        dm_req;
  logic        if_forced;
  logic        dm_grant;

  assign dm_req = DM_Read | DM_Write;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned StarveW =
      ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

  logic [StarveW-1:0] starve_q, starve_d;

  assign if_forced = IF_Read && (starve_q == StarveW'(STARVE_LIMIT));

  // Counts DM wins over a waiting IF; saturates at the limit until IF is served.
  always_comb begin
    starve_d = starve_q;
    if (state_q == StIdle) begin
      if (dm_grant) begin
        if (IF_Read && (starve_q != StarveW'(STARVE_LIMIT))) begin
          starve_d = starve_q + StarveW'(1);
        end
      end else if (IF_Read) begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign if_forced = 1'b0;
`endif

  assign dm_grant = dm_req && !if_forced;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dm_grant) begin
          state_d    = StBusyD;
          mem_addr_d = DM_Address;
          // A simultaneous read and write performs only the write.
          if (DM_Write) begin
            mem_wdata_d = DM_WriteData;
            mem_be_d    = DM_ByteEnable;
            mem_we_d    = 1'b1;
          end else begin
            mem_be_d = 4'b1111;
            mem_re_d = 1'b1;
          end
        end else if (IF_Read) begin
          state_d    = StBusyI;
          mem_addr_d = IF_Address;
          mem_be_d   = 4'b1111;
          mem_re_d   = 1'b1;
        end
      end

      StBusyI, StBusyD: begin
        if (Mem_Ack) begin
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = StResp;
          if_ack_d = (state_q == StBusyI);
          dm_ack_d = (state_q == StBusyD);
          if (mem_re_q) begin
            if (state_q == StBusyI) if_rdata_d = Mem_ReadData;
            else                    dm_rdata_d = Mem_ReadData;
          end
        end else begin
          tmo_d = tmo_q + 16'd1;
          if (tmo_d == 16'(TIMEOUT)) begin
            mem_re_d = 1'b0;
            mem_we_d = 1'b0;
            state_d  = StResp;
            err_d    = 1'b1;
            if_ack_d = (state_q == StBusyI);
            dm_ack_d = (state_q == StBusyD);
            if (mem_re_q) begin
              if (state_q == StBusyI) if_rdata_d = 32'h0;
              else                    dm_rdata_d = 32'h0;
            end
          end
        end
      end

      StResp: begin
        tmo_d   = 16'd0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      tmo_q       <= 16'd0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rdata_q  <= 32'h0;
      dm_rdata_q  <= 32'h0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
    end
  end

  assign Mem_Address     = mem_addr_q;
  assign Mem_WriteData   = mem_wdata_q;
  assign Mem_ByteEnable  = mem_be_q;
  assign Mem_ReadEnable  = mem_re_q;
  assign Mem_WriteEnable = mem_we_q;
  assign IF_ReadData     = if_rdata_q;
  assign DM_ReadData     = dm_rdata_q;
  assign IF_Ack          = if_ack_q;
  assign DM_Ack          = dm_ack_q;
  assign Err             = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT=8, STARVE_LIMIT=4).
module tb_mem_port_arbiter;

  localparam int unsigned TimeoutTb = 8;

  logic        CLK;
  logic        RST;
  logic        IF_Read;
  logic [31:0] IF_Address;
  logic [31:0] IF_ReadData;
  logic        IF_Ack;
  logic        DM_Read;
  logic        DM_Write;
  logic [31:0] DM_Address;
  logic [31:0] DM_WriteData;
  logic [3:0]  DM_ByteEnable;
  logic [31:0] DM_ReadData;
  logic        DM_Ack;
  logic [31:0] Mem_Address;
  logic [31:0] Mem_WriteData;
  logic [3:0]  Mem_ByteEnable;
  logic        Mem_ReadEnable;
  logic        Mem_WriteEnable;
  logic [31:0] Mem_ReadData;
  logic        Mem_Ack;
  logic        Err;

  int checks = 0;
  int fails  = 0;

  mem_port_arbiter #(
    .TIMEOUT     (TimeoutTb),
    .STARVE_LIMIT(4)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .IF_Read        (IF_Read),
    .IF_Address     (IF_Address),
    .IF_ReadData    (IF_ReadData),
    .IF_Ack         (IF_Ack),
    .DM_Read        (DM_Read),
    .DM_Write       (DM_Write),
    .DM_Address     (DM_Address),
    .DM_WriteData   (DM_WriteData),
    .DM_ByteEnable  (DM_ByteEnable),
    .DM_ReadData    (DM_ReadData),
    .DM_Ack         (DM_Ack),
    .Mem_Address    (Mem_Address),
    .Mem_WriteData  (Mem_WriteData),
    .Mem_ByteEnable (Mem_ByteEnable),
    .Mem_ReadEnable (Mem_ReadEnable),
    .Mem_WriteEnable(Mem_WriteEnable),
    .Mem_ReadData   (Mem_ReadData),
    .Mem_Ack        (Mem_Ack),
    .Err            (Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    IF_Read = 1'b0; IF_Address = 32'h0;
    DM_Read = 1'b0; DM_Write = 1'b0; DM_Address = 32'h0;
    DM_WriteData = 32'h0; DM_ByteEnable = 4'h0;
    Mem_ReadData = 32'h0; Mem_Ack = 1'b0;
    repeat (3) tick();
    checks++;
    if ({Mem_ReadEnable, Mem_WriteEnable, IF_Ack, DM_Ack, Err, Mem_ByteEnable} !== 9'h0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 0",
               {Mem_ReadEnable, Mem_WriteEnable, IF_Ack, DM_Ack, Err, Mem_ByteEnable});
    end
    checks++;
    if ({Mem_Address, Mem_WriteData, IF_ReadData, DM_ReadData} !== 128'h0) begin
      fails++;
      $display("FAIL reset_data: got %h want 0",
               {Mem_Address, Mem_WriteData, IF_ReadData, DM_ReadData});
    end
    RST = 1'b0;
    // A stray memory ack while idle must not produce anything.
    Mem_Ack = 1'b1;
    repeat (2) tick();
    Mem_Ack = 1'b0;
    checks++;
    if ({Mem_ReadEnable, Mem_WriteEnable, IF_Ack, DM_Ack, Err} !== 5'b0) begin
      fails++;
      $display("FAIL idle_stray_ack: got %b want 0",
               {Mem_ReadEnable, Mem_WriteEnable, IF_Ack, DM_Ack, Err});
    end
  endtask

  task automatic test_if_read();
    int en_cnt;
    IF_Read = 1'b1; IF_Address = 32'h100;
    tick();
    checks++;
    if ({Mem_ReadEnable, Mem_WriteEnable, Mem_ByteEnable} !== 6'b10_1111 ||
        Mem_Address !== 32'h100) begin
      fails++;
      $display("FAIL if_grant: got re/we/be=%b addr=%h want 101111 addr=00000100",
               {Mem_ReadEnable, Mem_WriteEnable, Mem_ByteEnable}, Mem_Address);
    end
    en_cnt = 0;
    while (Mem_ReadEnable === 1'b1 && en_cnt < 20) begin
      en_cnt++;
      if (en_cnt == 3) begin
        Mem_Ack = 1'b1;
        Mem_ReadData = 32'h2402000A;
      end
      tick();
      Mem_Ack = 1'b0;
    end
    checks++;
    if (en_cnt != 3) begin
      fails++;
      $display("FAIL if_strobe_len: got %0d want 3", en_cnt);
    end
    checks++;
    if ({IF_Ack, DM_Ack, Err} !== 3'b100 || IF_ReadData !== 32'h2402000A) begin
      fails++;
      $display("FAIL if_resp: got ack/dack/err=%b data=%h want 100 data=2402000a",
               {IF_Ack, DM_Ack, Err}, IF_ReadData);
    end
    IF_Read = 1'b0;
    tick();
    checks++;
    if (IF_Ack !== 1'b0) begin
      fails++;
      $display("FAIL if_ack_pulse: got %b want 0", IF_Ack);
    end
  endtask

  task automatic test_dm_read();
    DM_Read = 1'b1; DM_Address = 32'h84;
    tick();
    checks++;
    if ({Mem_ReadEnable, Mem_WriteEnable, Mem_ByteEnable} !== 6'b10_1111 ||
        Mem_Address !== 32'h84) begin
      fails++;
      $display("FAIL dm_read_grant: got re/we/be=%b addr=%h want 101111 addr=00000084",
               {Mem_ReadEnable, Mem_WriteEnable, Mem_ByteEnable}, Mem_Address);
    end
    tick();
    Mem_Ack = 1'b1; Mem_ReadData = 32'hCAFEF00D;
    tick();
    Mem_Ack = 1'b0; DM_Read = 1'b0;
    checks++;
    if ({DM_Ack, IF_Ack, Err} !== 3'b100 || DM_ReadData !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL dm_read_resp: got dack/iack/err=%b data=%h want 100 data=cafef00d",
               {DM_Ack, IF_Ack, Err}, DM_ReadData);
    end
    checks++;
    if (IF_ReadData !== 32'h2402000A) begin
      fails++;
      $display("FAIL if_data_kept: got %h want 2402000a", IF_ReadData);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int en;
    int gap;
    IF_Read = 1'b1; IF_Address = 32'h200;
    DM_Write = 1'b1; DM_Address = 32'h40; DM_WriteData = 32'hDEADBEEF; DM_ByteEnable = 4'b0011;
    tick();
    checks++;
    if ({Mem_WriteEnable, Mem_ReadEnable, Mem_ByteEnable} !== 6'b10_0011 ||
        Mem_Address !== 32'h40 || Mem_WriteData !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL b2b_dm_first: got we/re/be=%b addr=%h wd=%h want 100011 40 deadbeef",
               {Mem_WriteEnable, Mem_ReadEnable, Mem_ByteEnable}, Mem_Address, Mem_WriteData);
    end
    tick();
    Mem_Ack = 1'b1;
    tick();
    Mem_Ack = 1'b0; DM_Write = 1'b0;
    checks++;
    if ({DM_Ack, IF_Ack} !== 2'b10 || DM_ReadData !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL b2b_dm_ack: got dack/iack=%b rdata=%h want 10 rdata=cafef00d",
               {DM_Ack, IF_Ack}, DM_ReadData);
    end
    en = 0;
    gap = 0;
    Mem_ReadData = 32'h11112222;
    while (IF_Ack !== 1'b1 && gap < 20) begin
      if (Mem_ReadEnable === 1'b1) en++;
      Mem_Ack = (en == 2);
      tick();
      gap++;
    end
    Mem_Ack = 1'b0;
    checks++;
    if (gap != 4) begin
      fails++;
      $display("FAIL b2b_gap: got %0d want 4", gap);
    end
    checks++;
    if (IF_ReadData !== 32'h11112222 || DM_Ack !== 1'b0 || Mem_Address !== 32'h200) begin
      fails++;
      $display("FAIL b2b_if_resp: got data=%h dack=%b addr=%h want 11112222 0 00000200",
               IF_ReadData, DM_Ack, Mem_Address);
    end
    IF_Read = 1'b0;
    tick();
  endtask

  task automatic test_rw_both();
    DM_Read = 1'b1; DM_Write = 1'b1;
    DM_Address = 32'h44; DM_WriteData = 32'h12345678; DM_ByteEnable = 4'b1100;
    tick();
    checks++;
    if ({Mem_WriteEnable, Mem_ReadEnable, Mem_ByteEnable} !== 6'b10_1100 ||
        Mem_WriteData !== 32'h12345678) begin
      fails++;
      $display("FAIL rw_both_write: got we/re/be=%b wd=%h want 101100 12345678",
               {Mem_WriteEnable, Mem_ReadEnable, Mem_ByteEnable}, Mem_WriteData);
    end
    Mem_Ack = 1'b1; Mem_ReadData = 32'h99999999;
    tick();
    Mem_Ack = 1'b0; DM_Read = 1'b0; DM_Write = 1'b0;
    checks++;
    if (DM_Ack !== 1'b1 || DM_ReadData !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL rw_both_resp: got dack=%b rdata=%h want 1 cafef00d", DM_Ack, DM_ReadData);
    end
    tick();
  endtask

  task automatic test_timeout();
    int en;
    DM_Read = 1'b1; DM_Address = 32'h80;
    tick();
    en = 0;
    while (Mem_ReadEnable === 1'b1 && en < 20) begin
      en++;
      tick();
    end
    checks++;
    if (en != TimeoutTb) begin
      fails++;
      $display("FAIL timeout_len: got %0d want %0d", en, TimeoutTb);
    end
    checks++;
    if ({DM_Ack, Err, IF_Ack} !== 3'b110 || DM_ReadData !== 32'h0) begin
      fails++;
      $display("FAIL timeout_resp: got dack/err/iack=%b rdata=%h want 110 0",
               {DM_Ack, Err, IF_Ack}, DM_ReadData);
    end
    DM_Read = 1'b0;
    tick();
    checks++;
    if ({DM_Ack, Err} !== 2'b00) begin
      fails++;
      $display("FAIL timeout_pulse: got %b want 00", {DM_Ack, Err});
    end
  endtask

  task automatic test_reset_mid();
    DM_Read = 1'b1; DM_Address = 32'h90;
    tick();
    tick();
    RST = 1'b1;
    tick();
    checks++;
    if ({Mem_ReadEnable, Mem_WriteEnable, DM_Ack, IF_Ack, Err} !== 5'b0 ||
        IF_ReadData !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid: got ctrl=%b ifdata=%h want 0 0",
               {Mem_ReadEnable, Mem_WriteEnable, DM_Ack, IF_Ack, Err}, IF_ReadData);
    end
    RST = 1'b0;
    tick();
    checks++;
    if (Mem_ReadEnable !== 1'b1 || Mem_Address !== 32'h90 || DM_Ack !== 1'b0) begin
      fails++;
      $display("FAIL reset_regrant: got re=%b addr=%h dack=%b want 1 90 0",
               Mem_ReadEnable, Mem_Address, DM_Ack);
    end
    tick();
    Mem_Ack = 1'b1; Mem_ReadData = 32'h55AA55AA;
    tick();
    Mem_Ack = 1'b0; DM_Read = 1'b0;
    checks++;
    if ({DM_Ack, Err} !== 2'b10 || DM_ReadData !== 32'h55AA55AA) begin
      fails++;
      $display("FAIL reset_fresh_load: got dack/err=%b rdata=%h want 10 55aa55aa",
               {DM_Ack, Err}, DM_ReadData);
    end
    tick();
  endtask

  task automatic test_starvation();
    string seq;
    string want;
    int both;
    int n;
    seq = "";
    both = 0;
    n = 0;
`ifdef ARB_STARVE_GUARD_EN
    want = "DDDDIDDDDI";
`else
    want = "DDDDDDDDDD";
`endif
    DM_Read = 1'b1; DM_Address = 32'hA0;
    IF_Read = 1'b1; IF_Address = 32'h300;
    Mem_Ack = 1'b1; Mem_ReadData = 32'h0;
    while (seq.len() < 10 && n < 100) begin
      tick();
      n++;
      if (IF_Ack === 1'b1 && DM_Ack === 1'b1) both++;
      if (DM_Ack === 1'b1) seq = {seq, "D"};
      if (IF_Ack === 1'b1) seq = {seq, "I"};
    end
    Mem_Ack = 1'b0; DM_Read = 1'b0; IF_Read = 1'b0;
    checks++;
    if (seq != want) begin
      fails++;
      $display("FAIL starve_order: got %s want %s", seq, want);
    end
    checks++;
    if (both != 0) begin
      fails++;
      $display("FAIL dual_ack: got %0d want 0", both);
    end
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_dm_read();
    test_back_to_back();
    test_rw_both();
    test_timeout();
    test_reset_mid();
    test_starvation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
